// File: rtl/sme_pkg.sv
// sme_pkg: shared constants and state encoding for the SME multi-scan engine.
//   CH_ANY   '.' wildcard, matches any char (space included)
//   CH_BOL   '^' leading anchor: match must start a word
//   CH_EOL   '$' trailing anchor: match must end a word
//   CH_SPACE word separator used by both anchors
package sme_pkg;
  localparam logic [7:0] CH_ANY   = 8'h2E;
  localparam logic [7:0] CH_BOL   = 8'h5E;
  localparam logic [7:0] CH_EOL   = 8'h24;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;
endpackage

// File: rtl/sme_window_cmp.sv
// sme_window_cmp: combinational compare of the pattern against the string window
// starting at candidate position s.
//   str      stored string chars, str[0] first
//   pat      stored pattern chars (anchors already stripped)
//   s        candidate start position
//   len      effective pattern length L
//   str_len  number of valid string chars
//   bol/eol  leading / trailing word-anchor flags
//   hit      window at s satisfies pattern and both anchors
module sme_window_cmp
  import sme_pkg::*;
#(
  parameter int  CHAR_W  = 8,
  parameter int  MAX_STR = 32,
  parameter int  MAX_PAT = 8,
  localparam int STR_AW  = $clog2(MAX_STR),
  localparam int CNT_W   = $clog2(MAX_STR + 1),
  localparam int PL_W    = $clog2(MAX_PAT + 1)
) (
  input  logic [MAX_STR-1:0][CHAR_W-1:0] str,
  input  logic [MAX_PAT-1:0][CHAR_W-1:0] pat,
  input  logic [CNT_W-1:0]               s,
  input  logic [PL_W-1:0]                len,
  input  logic [CNT_W-1:0]               str_len,
  input  logic                           bol,
  input  logic                           eol,
  output logic                           hit
);
  int s_i, l_i, n_i;
  logic [MAX_PAT-1:0] lane_ok;
  logic [STR_AW-1:0]  bidx, eidx;
  logic               bol_ok, eol_ok;

  always_comb begin
    s_i = int'(s);
    l_i = int'(len);
    n_i = int'(str_len);
  end

  // One compare lane per pattern char; lanes past L are don't-care (forced ok).
  for (genvar i = 0; i < MAX_PAT; i++) begin : g_lane
    int                pos;
    logic [STR_AW-1:0] idx;
    logic              ok;
    always_comb begin
      pos = s_i + i;
      idx = STR_AW'(pos);
      ok  = 1'b1;
      if (i < l_i) begin
        if (pos >= MAX_STR)
          ok = 1'b0;
        else if (pat[i] != CHAR_W'(CH_ANY) && str[idx] != pat[i])
          ok = 1'b0;
      end
    end
    assign lane_ok[i] = ok;
  end

  always_comb begin
    bidx   = STR_AW'(s_i - 1);
    eidx   = STR_AW'(s_i + l_i);
    bol_ok = 1'b1;
    eol_ok = 1'b1;
    if (bol && s_i != 0)
      bol_ok = (str[bidx] == CHAR_W'(CH_SPACE));
    // s+L < str_len here whenever the length test passes, so eidx is in range.
    if (eol && (s_i + l_i) != n_i)
      eol_ok = (s_i + l_i < MAX_STR) && (str[eidx] == CHAR_W'(CH_SPACE));
    hit = (l_i != 0) && (s_i + l_i <= n_i) && (&lane_ok) && bol_ok && eol_ok;
  end
endmodule

// File: rtl/sme_multi_scan.sv
// sme_multi_scan: string-match engine. Loads a string (isstring framing) and a
// pattern (ispattern framing) one char per cycle, then scans every start position
// one per cycle and reports first/last match index plus occurrence count.
//   clk, reset    clock, async active-low reset
//   chardata      char sampled when isstring|ispattern
//   isstring      chardata is a string char (wins over ispattern)
//   ispattern     chardata is a pattern char
//   find_last     latched with first pattern char: report last instead of first hit
//   busy          high in SEARCH/DONE; loads ignored
//   valid         one-cycle result strobe
//   match         at least one occurrence
//   match_index   start of first/last occurrence (0 if none)
//   match_count   number of occurrences
module sme_multi_scan
  import sme_pkg::*;
#(
  parameter int  CHAR_W  = 8,
  parameter int  MAX_STR = 32,
  parameter int  MAX_PAT = 8,
  localparam int STR_AW  = $clog2(MAX_STR),
  localparam int CNT_W   = $clog2(MAX_STR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              find_last,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [STR_AW-1:0] match_index,
  output logic [CNT_W-1:0]  match_count
);
  localparam int PAT_AW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
  localparam int PL_W   = $clog2(MAX_PAT + 1);

  state_t                         state_q, state_d;
  logic [MAX_STR-1:0][CHAR_W-1:0] str_q, str_d;
  logic [CNT_W-1:0]               str_len_q, str_len_d;
  logic [MAX_PAT-1:0][CHAR_W-1:0] pat_q, pat_d;
  logic [PL_W-1:0]                pat_len_q, pat_len_d;
  logic                           bol_q, bol_d, eol_q, eol_d, last_q, last_d;
  logic [CNT_W-1:0]               s_q, s_d, cnt_q, cnt_d;
  logic [STR_AW-1:0]              idx_q, idx_d;
  logic                           found_q, found_d;
  logic                           valid_q, valid_d, match_q, match_d;
  logic [STR_AW-1:0]              mi_q, mi_d;
  logic [CNT_W-1:0]               mc_q, mc_d;

  logic                           hit;
  logic [CNT_W-1:0]               str_base;
  logic [PL_W-1:0]                pat_cap;
  logic [CHAR_W-1:0]              pat_last;

  sme_window_cmp #(.CHAR_W(CHAR_W), .MAX_STR(MAX_STR), .MAX_PAT(MAX_PAT)) u_cmp (
    .str(str_q), .pat(pat_q), .s(s_q), .len(pat_len_q), .str_len(str_len_q),
    .bol(bol_q), .eol(eol_q), .hit(hit)
  );

  always_comb begin
    state_d   = state_q;
    str_d     = str_q;
    str_len_d = str_len_q;
    pat_d     = pat_q;
    pat_len_d = pat_len_q;
    bol_d     = bol_q;
    eol_d     = eol_q;
    last_d    = last_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    found_d   = found_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    mi_d      = mi_q;
    mc_d      = mc_q;

    // A string frame starting outside LOAD_STR overwrites from position 0.
    str_base = (state_q == LOAD_STR) ? str_len_q : '0;
    // A leading '^' occupies one of the MAX_PAT slots.
    pat_cap  = PL_W'(MAX_PAT) - PL_W'(bol_q);
    pat_last = pat_q[PAT_AW'(pat_len_q - PL_W'(1))];

    case (state_q)
      IDLE, LOAD_STR: begin
        if (isstring) begin
          state_d = LOAD_STR;
          if (str_base < CNT_W'(MAX_STR)) begin
            str_d[STR_AW'(str_base)] = chardata;
            str_len_d = str_base + CNT_W'(1);
          end else begin
            str_len_d = str_base;
          end
        end else if (ispattern) begin
          state_d   = LOAD_PAT;
          last_d    = find_last;
          eol_d     = 1'b0;
          bol_d     = (chardata == CHAR_W'(CH_BOL));
          pat_len_d = '0;
          if (!bol_d) begin
            pat_d[0]  = chardata;
            pat_len_d = PL_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_PAT: begin
        if (!ispattern) begin
          // Pattern-end edge: strip a trailing '$' and start the scan.
          if (pat_len_q != '0 && pat_last == CHAR_W'(CH_EOL)) begin
            eol_d     = 1'b1;
            pat_len_d = pat_len_q - PL_W'(1);
          end
          s_d     = '0;
          cnt_d   = '0;
          idx_d   = '0;
          found_d = 1'b0;
          state_d = SEARCH;
        end else if (!isstring && pat_len_q < pat_cap) begin
          pat_d[PAT_AW'(pat_len_q)] = chardata;
          pat_len_d = pat_len_q + PL_W'(1);
        end
      end
      SEARCH: begin
        if (hit) begin
          cnt_d   = cnt_q + CNT_W'(1);
          found_d = 1'b1;
          if (last_q || !found_q) idx_d = STR_AW'(s_q);
        end
        // s runs 0..str_len inclusive; s==str_len never hits but sets the
        // fixed str_len+1 latency, including the empty-string case.
        if (s_q == str_len_q) begin
          state_d = DONE;
          valid_d = 1'b1;
          match_d = found_d;
          mi_d    = idx_d;
          mc_d    = cnt_d;
        end else begin
          s_d = s_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      str_q     <= '0;
      str_len_q <= '0;
      pat_q     <= '0;
      pat_len_q <= '0;
      bol_q     <= 1'b0;
      eol_q     <= 1'b0;
      last_q    <= 1'b0;
      s_q       <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      mi_q      <= '0;
      mc_q      <= '0;
    end else begin
      state_q   <= state_d;
      str_q     <= str_d;
      str_len_q <= str_len_d;
      pat_q     <= pat_d;
      pat_len_q <= pat_len_d;
      bol_q     <= bol_d;
      eol_q     <= eol_d;
      last_q    <= last_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      mi_q      <= mi_d;
      mc_q      <= mc_d;
    end
  end

  assign busy        = (state_q == SEARCH) || (state_q == DONE);
  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = mi_q;
  assign match_count = mc_q;
endmodule

// File: tb/tb_sme_multi_scan.sv
// tb_sme_multi_scan: directed bench for sme_multi_scan. A string-level model
// predicts each result and its strobe cycle; a per-cycle compare process checks
// valid and the held result outputs, and each test also pins literal values.
module tb_sme_multi_scan;
  localparam int MAX_STR = 32;
  localparam int MAX_PAT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] chardata = '0;
  logic       isstring = 1'b0, ispattern = 1'b0, find_last = 1'b0;
  logic       busy, valid, match;
  logic [4:0] match_index;
  logic [5:0] match_count;

  int errs = 0, checks = 0, cyc = 0;
  string mstr = "";
  bit pend = 1'b0;
  int exp_cyc = 0, n0 = 0;
  logic       e_m = 1'b0, h_m = 1'b0;
  logic [4:0] e_i = '0, h_i = '0;
  logic [5:0] e_c = '0, h_c = '0;

  sme_multi_scan dut (
    .clk(clk), .reset(rst_n), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .find_last(find_last), .busy(busy), .valid(valid),
    .match(match), .match_index(match_index), .match_count(match_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scan every start position of the stored (truncated) string.
  function automatic void model(input string p, input bit fl, output logic m,
                                output logic [4:0] idx, output logic [5:0] cnt);
    string q;
    bit bol, eol, ok;
    int L, n, c, ix;
    q = (p.len() > MAX_PAT) ? p.substr(0, MAX_PAT - 1) : p;
    bol = (q.len() > 0) && (q[0] == 8'h5E);
    if (bol) q = q.substr(1, q.len() - 1);
    eol = (q.len() > 0) && (q[q.len() - 1] == 8'h24);
    if (eol) q = q.substr(0, q.len() - 2);
    L = q.len(); n = mstr.len(); c = 0; ix = 0;
    for (int s = 0; L > 0 && s + L <= n; s++) begin
      ok = 1'b1;
      for (int j = 0; j < L; j++)
        if (q[j] != 8'h2E && q[j] != mstr[s + j]) ok = 1'b0;
      if (bol && s != 0 && mstr[s - 1] != 8'h20) ok = 1'b0;
      if (eol && s + L != n && mstr[s + L] != 8'h20) ok = 1'b0;
      if (ok) begin
        c++;
        if (fl || c == 1) ix = s;
      end
    end
    m = (c != 0); idx = 5'(ix); cnt = 6'(c);
  endfunction

  // Per-cycle compare: strobe only at the predicted cycle, results held otherwise.
  always @(negedge clk) begin
    bit ev;
    ev = pend && (cyc == exp_cyc);
    checks++;
    if (valid !== ev) begin
      errs++; $display("FAIL valid_strobe cyc=%0d got=%b want=%b", cyc, valid, ev);
    end
    if (ev) begin h_m = e_m; h_i = e_i; h_c = e_c; pend = 1'b0; end
    checks += 3;
    if (match !== h_m) begin
      errs++; $display("FAIL held_match cyc=%0d got=%b want=%b", cyc, match, h_m);
    end
    if (match_index !== h_i) begin
      errs++; $display("FAIL held_index cyc=%0d got=%0d want=%0d", cyc, match_index, h_i);
    end
    if (match_count !== h_c) begin
      errs++; $display("FAIL held_count cyc=%0d got=%0d want=%0d", cyc, match_count, h_c);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i]; isstring = 1'b1; tick();
    end
    isstring = 1'b0; chardata = '0;
    mstr = (s.len() > MAX_STR) ? s.substr(0, MAX_STR - 1) : s;
    tick();
  endtask

  task automatic send_pat(input string p, input bit fl);
    for (int i = 0; i < p.len(); i++) begin
      chardata = p[i]; ispattern = 1'b1; find_last = fl; tick();
    end
    ispattern = 1'b0; chardata = '0;
    model(p, fl, e_m, e_i, e_c);
    tick();                              // pattern-end edge
    n0 = cyc; exp_cyc = cyc + mstr.len() + 1; pend = 1'b1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0 ||
        match_count !== 6'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s got v=%b m=%b i=%0d c=%0d b=%b want all 0", name, valid,
               match, match_index, match_count, busy);
    end
  endtask

  task automatic wait_result(input string name, input logic em, input int ei,
                             input int ec, input int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errs++; $display("FAIL %s_timeout got no valid want valid within 100 cycles", name);
    end else begin
      checks += 5;
      if (cyc - n0 != lat) begin
        errs++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc - n0, lat);
      end
      if (match !== em) begin
        errs++; $display("FAIL %s_match got=%b want=%b", name, match, em);
      end
      if (match_index !== 5'(ei)) begin
        errs++; $display("FAIL %s_index got=%0d want=%0d", name, match_index, ei);
      end
      if (match_count !== 6'(ec)) begin
        errs++; $display("FAIL %s_count got=%0d want=%0d", name, match_count, ec);
      end
      if (e_m !== em || e_i !== 5'(ei) || e_c !== 6'(ec)) begin
        errs++;
        $display("FAIL %s_model got m=%b i=%0d c=%0d want m=%b i=%0d c=%0d", name,
                 e_m, e_i, e_c, em, ei, ec);
      end
    end
    tick();                              // consume the DONE cycle
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1);
  end

  initial begin
    string long_s;
    repeat (3) tick();
    check_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // 1
    send_str("hello world");
    send_pat("wor", 1'b0);    wait_result("t1_wor", 1'b1, 6, 1, 12);
    // 2
    send_str("abcabcab");
    send_pat("ab", 1'b0);     wait_result("t2_first", 1'b1, 0, 3, 9);
    send_pat("ab", 1'b1);     wait_result("t2_last", 1'b1, 6, 3, 9);
    // 3
    send_str("cat concat");
    send_pat("^cat", 1'b0);   wait_result("t3_bol", 1'b1, 0, 1, 11);
    send_pat("cat$", 1'b1);   wait_result("t3_eol", 1'b1, 7, 2, 11);
    send_pat("^con", 1'b0);   wait_result("t3_con", 1'b1, 4, 1, 11);
    // 4
    send_str("cut cot");
    send_pat("c.t", 1'b0);    wait_result("t4_wild", 1'b1, 0, 2, 8);
    send_str("ab");
    send_pat("abc", 1'b0);    wait_result("t4_long", 1'b0, 0, 0, 3);
    // 5: abort mid-scan
    send_str("hello world");
    send_pat("wor", 1'b0);
    repeat (3) tick();
    rst_n = 1'b0; pend = 1'b0; h_m = 1'b0; h_i = '0; h_c = '0; mstr = "";
    #1 check_zero("t5_abort");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (14) tick();
    check_zero("t5_after");
    send_str("xy");
    send_pat("y", 1'b0);      wait_result("t5_reload", 1'b1, 1, 1, 3);
    // 6: overflow truncation and bare anchor
    long_s = "";
    for (int i = 0; i < 32; i++) long_s = {long_s, "a"};
    long_s = {long_s, "ZZZZZZZZ"};
    send_str(long_s);
    send_pat("ZZZZZZZZ", 1'b0); wait_result("t6_trunc", 1'b0, 0, 0, 33);
    send_pat("^", 1'b0);        wait_result("t6_bare", 1'b0, 0, 0, 33);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
